// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsa_pkg
// Description : Shared types and limits for the reversible serial adder
//               controller (FSM state encoding, maximum operand width).
// Revision    : 1.0 - initial release
// ============================================================================
package rsa_pkg;

    // Widest operand the controller is meant to be built with.
    localparam int RSA_MAX_WIDTH = 32;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rsa_state_t;

endpackage
`default_nettype wire

// File: rtl/reversible_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : reversible_full_adder
// Description : 1-bit full adder built from two cascaded Peres gates. The
//               out_vec lines carry the garbage outputs needed to keep the
//               mapping reversible; callers normally leave them unused.
// Revision    : 1.0 - initial release
// ============================================================================
module reversible_full_adder (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    output logic       sum,
    output logic       cout,
    output logic [3:0] out_vec
);

    logic w_p;  // first Peres gate: a ^ b
    logic w_g;  // first Peres gate: a & b (ancilla initialised to 0)

    assign w_p  = a ^ b;
    assign w_g  = a & b;

    // Second Peres gate folds the carry-in into the propagate/generate pair.
    assign sum  = w_p ^ cin;
    assign cout = (w_p & cin) ^ w_g;

    // Garbage lines: pass-through copies that make the cell invertible.
    assign out_vec = {a, w_p, w_g, cin};

endmodule
`default_nettype wire

// File: rtl/reversible_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reversible_serial_adder_ctrl
// Description : Bit-serial WIDTH-bit adder that steps a single
//               reversible_full_adder cell once per clock, LSB first, with
//               the ripple carry held in a register. One-cycle done pulse.
//               Optional macro RSA_OVERFLOW_EN adds a signed-overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
module reversible_serial_adder_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8   // legal range 2..RSA_MAX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef RSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    // The counter stops at the last bit index, so it never wraps.
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    rsa_state_t       r_state;
    rsa_state_t       w_next_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [3:0]       w_unused_out_vec;
    logic             w_last_bit;

    assign w_last_bit = (r_cnt == C_LAST_BIT);

    // Shared 1-bit cell, always fed from the LSB of the operand shifters.
    reversible_full_adder u_fa (
        .a       (r_sa[0]),
        .b       (r_sb[0]),
        .cin     (r_carry),
        .sum     (w_fa_sum),
        .cout    (w_fa_cout),
        .out_vec (w_unused_out_vec)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: start only matters in IDLE; DONE always returns.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_last_bit) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: operand load on accepted start, one bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                    end
                end
                RUN: begin
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
                    r_carry <= w_fa_cout;
                    if (w_last_bit) begin
                        r_cout <= w_fa_cout;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // DONE: results are held for the consumer.
                end
            endcase
        end
    end

`ifdef RSA_OVERFLOW_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_ovf <= 1'b0;
        end else if ((r_state == RUN) && w_last_bit) begin
            r_ovf <= r_carry ^ w_fa_cout;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_reversible_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reversible_serial_adder_ctrl
// Description : Self-checking bench for reversible_serial_adder_ctrl. An
//               8-bit instance covers directed, random, ignored-start and
//               abort cases; a 2-bit instance is swept exhaustively with
//               back-to-back operations. Expected values come from plain
//               integer addition.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reversible_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       ovf8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       cin2 = 1'b0;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;
    logic       ovf2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reversible_serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef RSA_OVERFLOW_EN
        ,
        .ovf   (ovf8)
`endif
    );

    reversible_serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2)
`ifdef RSA_OVERFLOW_EN
        ,
        .ovf   (ovf2)
`endif
    );

`ifndef RSA_OVERFLOW_EN
    assign ovf8 = 1'b0;
    assign ovf2 = 1'b0;
`endif

    // Issue one 8-bit operation and observe it for 20 cycles after the start edge.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                         output logic [7:0] s, output logic co, output logic ov,
                         output int lat, output int busy_n, output int done_n);
        @(negedge clk);
        a8 = ta; b8 = tbv; cin8 = tc; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = -1; busy_n = 0; done_n = 0; s = '0; co = 1'b0; ov = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (busy8) busy_n++;
            if (done8) begin
                done_n++;
                if (lat < 0) begin
                    lat = k; s = sum8; co = cout8; ov = ovf8;
                end
            end
            @(negedge clk);
        end
    endtask

    // Check one 8-bit operation fully against the integer model.
    task automatic check_op8(input string name, input logic [7:0] ta, input logic [7:0] tbv,
                             input logic tc, input bit check_timing);
        logic [7:0] s;
        logic       co, ov;
        int         lat, bn, dn;
        logic [8:0] e;
        logic       e_ovf;
        e     = 9'(ta) + 9'(tbv) + 9'(tc);
        e_ovf = (ta[7] == tbv[7]) && (e[7] != ta[7]);
        do_op(ta, tbv, tc, s, co, ov, lat, bn, dn);
        checks++;
        if ({co, s} !== e) begin
            failures++;
            $display("FAIL %s result a=%h b=%h cin=%0d got {cout,sum}=%h expected %h", name, ta, tbv, tc, {co, s}, e);
        end
        checks++;
        if ({cout8, sum8} !== e) begin
            failures++;
            $display("FAIL %s held_result got %h expected %h", name, {cout8, sum8}, e);
        end
`ifdef RSA_OVERFLOW_EN
        checks++;
        if (ov !== e_ovf) begin
            failures++;
            $display("FAIL %s ovf a=%h b=%h got %0d expected %0d", name, ta, tbv, ov, e_ovf);
        end
`endif
        if (check_timing) begin
            checks++;
            if (lat !== 8) begin
                failures++;
                $display("FAIL %s done_latency got %0d expected 8", name, lat);
            end
            checks++;
            if (bn !== 8) begin
                failures++;
                $display("FAIL %s busy_cycles got %0d expected 8", name, bn);
            end
            checks++;
            if (dn !== 1) begin
                failures++;
                $display("FAIL %s done_pulses got %0d expected 1", name, dn);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy8, done8, cout8, sum8, ovf8} !== 12'h000) begin
            failures++;
            $display("FAIL reset8 busy=%0d done=%0d cout=%0d sum=%h ovf=%0d expected all 0", busy8, done8, cout8, sum8, ovf8);
        end
        checks++;
        if ({busy2, done2, cout2, sum2, ovf2} !== 6'h00) begin
            failures++;
            $display("FAIL reset2 busy=%0d done=%0d cout=%0d sum=%h ovf=%0d expected all 0", busy2, done2, cout2, sum2, ovf2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] ta [6] = '{8'h5A, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h10};
        logic [7:0] tbv[6] = '{8'h3C, 8'h01, 8'hFF, 8'h01, 8'hFF, 8'h20};
        logic       tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            check_op8($sformatf("directed%0d", i), ta[i], tbv[i], tc[i], 1'b1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            check_op8($sformatf("random%0d", i), 8'($urandom), 8'($urandom),
                      1'($urandom_range(0, 1)), (i < 3));
        end
    endtask

    task automatic test_start_ignored();
        int         dn;
        logic [7:0] s;
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dn = 0; s = 8'hEE;
        for (int k = 0; k < 24; k++) begin
            if (done8) begin
                dn++;
                s = sum8;
            end
            if (k == 3) begin
                a8 = 8'hAA; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (s !== 8'h02) begin
            failures++;
            $display("FAIL start_ignored sum got %h expected 02", s);
        end
        checks++;
        if (dn !== 1) begin
            failures++;
            $display("FAIL start_ignored done_pulses got %0d expected 1", dn);
        end
    endtask

    task automatic test_reset_abort();
        int dn;
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy8, done8, cout8, sum8} !== 11'h000) begin
            failures++;
            $display("FAIL reset_abort busy=%0d done=%0d cout=%0d sum=%h expected all 0", busy8, done8, cout8, sum8);
        end
        dn = 0;
        for (int k = 0; k < 15; k++) begin
            if (done8) dn++;
            @(negedge clk);
        end
        checks++;
        if (dn !== 0) begin
            failures++;
            $display("FAIL reset_abort done_pulses got %0d expected 0", dn);
        end
        check_op8("after_abort", 8'h03, 8'h04, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back_w2();
        logic [2:0] q[$];
        logic [2:0] e;
        int         idx, last_done, ndone;
        idx = 0; last_done = -1; ndone = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 300 && !(idx == 32 && q.size() == 0); cyc++) begin
            if (done2) begin
                ndone++;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL w2_unexpected_done at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    if ({cout2, sum2} !== e) begin
                        failures++;
                        $display("FAIL w2_result op%0d got %h expected %h", ndone - 1, {cout2, sum2}, e);
                    end
                end
                if (last_done >= 0) begin
                    checks++;
                    if (cyc - last_done !== 4) begin
                        failures++;
                        $display("FAIL w2_done_spacing got %0d expected 4", cyc - last_done);
                    end
                end
                last_done = cyc;
            end
            if (!busy2 && !done2 && idx < 32) begin
                {a2, b2, cin2} = idx[4:0];
                start2 = 1'b1;
                q.push_back(3'(a2) + 3'(b2) + 3'(cin2));
                idx++;
            end else begin
                start2 = 1'b0;
            end
            @(negedge clk);
        end
        start2 = 1'b0;
        checks++;
        if (ndone !== 32) begin
            failures++;
            $display("FAIL w2_completed got %0d expected 32", ndone);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back_w2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-time bound so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
